matvec_seq: RTL and testbench
=============================

Name: matvec_seq

Overview:
- Sequential matrix-vector multiplier computing y = A·x, one multiply-accumulate per clock.
- Sits directly upstream of the bias adder in the RBM datapath: its packed result vector is the operand the adder sums with the bias vector.
- Operands and result use the codebase's flat packed-port format; a start/valid/ready handshake brackets each job.

Parameters:
- bitlength, 8, width of every matrix, vector and result element (unsigned).
- ROWS, 7, number of matrix rows, equal to the result vector length.
- COLS, 7, number of matrix columns, equal to the input vector length.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- AI  input  ROWS*COLS*bitlength  packed matrix; element [i][j] at bits (i*COLS+j)*bitlength +: bitlength.
- XI  input  COLS*bitlength  packed vector; element [j] at bits j*bitlength +: bitlength.
- busy  output  1  high in RUN and DONE.
- valid  output  1  result available (DONE state).
- ready  input  1  downstream accepts result when valid&&ready.
- YO  output  ROWS*bitlength  packed result; element [i] at bits i*bitlength +: bitlength.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, valid=0, YO=0, row/col counters=0, accumulator=0, operand registers=0. Takes effect immediately, including mid-job; the partial job is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at a rising edge:
  - AI and XI are captured into internal registers.
  - r=0, c=0, acc=0; go to RUN.
  - After capture, AI and XI may change freely.
- RUN, each cycle: acc_next = acc + A[r][c]*X[c].
  - If c<COLS-1: acc<=acc_next, c<=c+1.
  - If c==COLS-1: Y[r] <= acc_next[bitlength-1:0], acc<=0, c<=0, r<=r+1.
  - If additionally r==ROWS-1: go to DONE.
- Accumulator width: 2*bitlength+clog2(COLS) bits, so no internal overflow. The result is truncated modulo 2^bitlength, matching the wrap semantics of the downstream adder.
- Latency: start sampled at edge N; valid rises after edge N+ROWS*COLS (49 cycles at defaults). Exactly one MAC per cycle, no bubbles.
- DONE: valid=1 and YO is held stable.
  - On a rising edge with ready=1: go to IDLE and valid<=0.
  - YO keeps its last value in IDLE until the next job overwrites rows.
- YO rows update progressively during RUN; the consumer uses YO only while valid=1.
- start while RUN or DONE is ignored, with no queueing. This includes start=1 coincident with the accepting edge in DONE: the FSM must pass through IDLE before a new start is sampled.
- ready is ignored outside DONE.
- busy = (state != IDLE); valid = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- ROWS=1 or COLS=1 must work: the c==COLS-1 and r==ROWS-1 conditions may be true from the first cycle.

Test Plan:
- Ground truth: A[i][j]=2i+j, x[j]=1, start pulse 1 cycle, ready=1 -> valid exactly 49 cycles after the start edge; Y = {21,35,49,63,77,91,105} for i=0..6; valid for 1 cycle, then IDLE.
- Overflow wrap: all A=255, x=255 -> each row sum 455175; Y[i]=7 for all i (455175 mod 256).
- Backpressure: identity A, x[j]=j+3, ready held 0 for 10 cycles after valid -> valid and YO={3..9} stable for all 10 cycles; clears one edge after ready=1.
- Ignored start: assert start at cycles 5 and 30 of RUN, and again coincident with acceptance -> no restart; result equals single-job result; IDLE reached with busy=0 for at least 1 cycle.
- Operand capture: change AI/XI to all-zero one cycle after the start edge -> result still computed from captured operands (Y={21,...,105} as in the ground-truth case).
- Async reset mid-job: drive rst_n=0 between clock edges at cycle 20 of RUN -> busy, valid and YO drop to 0 immediately. After release, a fresh job with the ground-truth inputs yields the correct Y.

Source files
------------

// File: rtl/matvec_seq.sv
// matvec_seq: sequential matrix-vector multiplier, y = A*x, one MAC per clock.
// Feeds the bias adder of the RBM datapath; results wrap modulo 2^bitlength.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset; aborts any job in progress
//   start  - job request, sampled only while idle
//   AI     - packed matrix, element [i][j] at (i*COLS+j)*bitlength +: bitlength
//   XI     - packed vector, element [j] at j*bitlength +: bitlength
//   busy   - high while a job is running or its result is waiting
//   valid  - result on YO is complete and stable
//   ready  - downstream accepts the result when valid && ready
//   YO     - packed result, element [i] at i*bitlength +: bitlength
module matvec_seq #(
    parameter int bitlength = 8,
    parameter int ROWS      = 7,
    parameter int COLS      = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ROWS*COLS*bitlength-1:0] AI,
    input  logic [COLS*bitlength-1:0]      XI,
    output logic                          busy,
    output logic                          valid,
    input  logic                          ready,
    output logic [ROWS*bitlength-1:0]      YO
);

    // Wide enough to sum COLS full-scale products without overflow.
    localparam int AW = 2*bitlength + $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROWS-1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS-1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                          state;
    logic [ROWS*COLS*bitlength-1:0]  a_reg;
    logic [COLS*bitlength-1:0]       x_reg;
    logic [ROWS*bitlength-1:0]       y_reg;
    logic [RW-1:0]                   r;
    logic [CW-1:0]                   c;
    logic [AW-1:0]                   acc;

    logic [bitlength-1:0]            a_el;
    logic [bitlength-1:0]            x_el;
    logic [2*bitlength-1:0]          prod;
    logic [AW-1:0]                   acc_next;

    always_comb begin
        a_el     = a_reg[(int'(r)*COLS + int'(c))*bitlength +: bitlength];
        x_el     = x_reg[int'(c)*bitlength +: bitlength];
        prod     = {{bitlength{1'b0}}, a_el} * {{bitlength{1'b0}}, x_el};
        acc_next = acc + AW'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            x_reg <= '0;
            y_reg <= '0;
            r     <= '0;
            c     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= AI;
                        x_reg <= XI;
                        r     <= '0;
                        c     <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (c == C_LAST) begin
                        // Last column of the row: commit the truncated sum and
                        // restart the accumulator for the next row in the same cycle.
                        y_reg[int'(r)*bitlength +: bitlength] <= acc_next[bitlength-1:0];
                        acc <= '0;
                        c   <= '0;
                        r   <= r + RW'(1);
                        if (r == R_LAST) begin
                            state <= DONE;
                        end
                    end else begin
                        acc <= acc_next;
                        c   <= c + CW'(1);
                    end
                end
                DONE: begin
                    if (ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure decodes of the state register: no path from any input.
    assign busy  = (state != IDLE);
    assign valid = (state == DONE);
    assign YO    = y_reg;

endmodule

// File: tb/tb_matvec_seq.sv
// tb_matvec_seq: directed self-checking bench for matvec_seq at default sizes
// (bitlength=8, ROWS=7, COLS=7). Expected results are hand-computed constants.
module tb_matvec_seq;

    localparam int BL = 8;
    localparam int R  = 7;
    localparam int C  = 7;
    localparam int unsigned LAT   = 49;
    localparam int unsigned BOUND = 60;

    // Row sums 14*i + 21 for A[i][j] = 2i+j, x[j] = 1.
    localparam logic [R*BL-1:0] Y_GROUND = {8'd105, 8'd91, 8'd77, 8'd63, 8'd49, 8'd35, 8'd21};
    // 7 * 255 * 255 = 455175 = 0x6F207, low byte 0x07.
    localparam logic [R*BL-1:0] Y_OVF    = {8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    // Identity matrix, x[j] = j + 3.
    localparam logic [R*BL-1:0] Y_BP     = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [R*C*BL-1:0]     ai;
    logic [C*BL-1:0]       xi;
    logic                  busy;
    logic                  valid;
    logic                  ready;
    logic [R*BL-1:0]       yo;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned lat;

    matvec_seq #(
        .bitlength(BL),
        .ROWS     (R),
        .COLS     (C)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .AI   (ai),
        .XI   (xi),
        .busy (busy),
        .valid(valid),
        .ready(ready),
        .YO   (yo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ground();
        for (int unsigned i = 0; i < R; i++)
            for (int unsigned j = 0; j < C; j++)
                ai[(i*C+j)*BL +: BL] = BL'(2*i + j);
        for (int unsigned j = 0; j < C; j++)
            xi[j*BL +: BL] = 8'd1;
    endtask

    task automatic set_identity();
        for (int unsigned i = 0; i < R; i++)
            for (int unsigned j = 0; j < C; j++)
                ai[(i*C+j)*BL +: BL] = (i == j) ? 8'd1 : 8'd0;
        for (int unsigned j = 0; j < C; j++)
            xi[j*BL +: BL] = BL'(j + 3);
    endtask

    // Pulse start across one edge, then count edges until valid (bounded).
    // poke_a/poke_b: edge counts after which start is re-asserted (0 = none).
    // zero_ops: clear AI/XI one cycle after the start edge.
    task automatic launch_and_wait(input int unsigned poke_a, input int unsigned poke_b,
                                   input bit zero_ops, output int unsigned cnt);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        cnt = 0;
        while (!valid && cnt < BOUND) begin
            start = (cnt != 0) && (cnt == poke_a || cnt == poke_b);
            if (zero_ops && cnt == 1) begin
                ai = '0;
                xi = '0;
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        start = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        ready   = 1'b1;
        ai      = '0;
        xi      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_yo",    64'(yo),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ground truth, ready held high
        set_ground();
        launch_and_wait(0, 0, 1'b0, lat);
        check("gt_latency", 64'(lat), 64'(LAT));
        check("gt_valid",   64'(valid), 64'd1);
        check("gt_yo",      64'(yo), 64'(Y_GROUND));
        @(posedge clk);
        #1;
        check("gt_valid_one_cycle", 64'(valid), 64'd0);
        check("gt_idle_busy",       64'(busy),  64'd0);
        check("gt_yo_held_idle",    64'(yo),    64'(Y_GROUND));

        // Overflow wrap
        ai = '1;
        xi = '1;
        launch_and_wait(0, 0, 1'b0, lat);
        check("ovf_latency", 64'(lat), 64'(LAT));
        check("ovf_yo",      64'(yo),  64'(Y_OVF));
        @(posedge clk);
        #1;

        // Backpressure
        ready = 1'b0;
        set_identity();
        launch_and_wait(0, 0, 1'b0, lat);
        check("bp_latency", 64'(lat), 64'(LAT));
        for (int unsigned k = 0; k < 10; k++) begin
            check("bp_yo", 64'(yo), 64'(Y_BP));
            check("bp_valid_hold", 64'(valid), 64'd1);
            @(posedge clk);
            #1;
        end
        check("bp_still_valid", 64'(valid), 64'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(valid), 64'd0);
        check("bp_release_busy",  64'(busy),  64'd0);

        // Ignored start during RUN and on the accepting edge
        ready = 1'b0;
        set_ground();
        launch_and_wait(5, 30, 1'b0, lat);
        check("ign_latency", 64'(lat), 64'(LAT));
        check("ign_yo",      64'(yo),  64'(Y_GROUND));
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_accept_valid", 64'(valid), 64'd0);
        check("ign_accept_busy",  64'(busy),  64'd0);
        @(posedge clk);
        #1;
        check("ign_idle_busy", 64'(busy), 64'd0);

        // Operand capture: inputs cleared one cycle after start
        set_ground();
        launch_and_wait(0, 0, 1'b1, lat);
        check("cap_latency", 64'(lat), 64'(LAT));
        check("cap_yo",      64'(yo),  64'(Y_GROUND));
        @(posedge clk);
        #1;

        // Async reset mid-job
        set_ground();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("arst_partial_row0", 64'(yo[BL-1:0]), 64'd21);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(busy),  64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_yo",    64'(yo),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch_and_wait(0, 0, 1'b0, lat);
        check("arst_rerun_latency", 64'(lat), 64'(LAT));
        check("arst_rerun_yo",      64'(yo),  64'(Y_GROUND));
        @(posedge clk);
        #1;
        check("arst_rerun_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
